arbiter_wrr_pkt: RTL and testbench

- Packet-aware weighted round-robin arbiter that shares one downstream valid/ready channel among N_IN requesters.
- A grant is held for whole packets, delimited by `last`. Each grant may carry up to `weight` packets before the grant rotates.
- The output is registered for timing.
- Sits in front of shared datapath resources where the 2-input single-beat round-robin is insufficient: more inputs, bursts, bandwidth shaping.

---
 rtl/arbiter_wrr_pkt.sv | 154 +++++++++++++++
 tb/tb_arbiter_wrr_pkt.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_wrr_pkt.sv
// arbiter_wrr_pkt: packet-aware weighted round-robin arbiter.
// Shares one registered valid/ready output channel among N_IN requesters.
// A grant is held for whole packets (delimited by last) and may carry up to
// weight[i] packets (0 counts as 1) before the round-robin pointer rotates.
module arbiter_wrr_pkt #(
  parameter int DWIDTH = 20,
  parameter int N_IN   = 4,
  parameter int WWIDTH = 4,
  parameter int SWIDTH = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN*DWIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]          in_last,
  output logic [N_IN-1:0]          in_ready,
  input  logic [N_IN*WWIDTH-1:0]   weight,
  output logic                     out_valid,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_last,
  output logic [SWIDTH-1:0]        out_src,
  input  logic                     out_ready
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg, state_next;
  logic [SWIDTH-1:0] ptr_reg, ptr_next;
  logic [SWIDTH-1:0] gnt_reg, gnt_next;
  logic [WWIDTH-1:0] credit_reg, credit_next;
  logic              boundary_reg, boundary_next;
  logic              out_valid_reg, out_valid_next;
  logic [DWIDTH-1:0] out_data_reg, out_data_next;
  logic              out_last_reg, out_last_next;
  logic [SWIDTH-1:0] out_src_reg, out_src_next;

  logic [WWIDTH-1:0] w_arr [N_IN];
  logic [DWIDTH-1:0] d_arr [N_IN];
  logic [SWIDTH-1:0] idx;
  logic [SWIDTH-1:0] sel;
  logic              found;
  logic              ready_g;
  logic              accept;

  // Unpack the flat per-requester buses into indexable arrays.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign w_arr[gi] = weight[gi*WWIDTH +: WWIDTH];
    assign d_arr[gi] = in_data[gi*DWIDTH +: DWIDTH];
  end

  // Rotating priority search: first valid requester after ptr, wrapping at N_IN.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = ptr_reg;
    for (int k = 0; k < N_IN; k++) begin
      idx = (idx == SWIDTH'(N_IN - 1)) ? '0 : idx + 1'b1;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state and handshake logic for the IDLE/GRANT controller and output register.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_next       = gnt_reg;
    credit_next    = credit_reg;
    boundary_next  = boundary_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    out_src_next   = out_src_reg;
    in_ready       = '0;
    ready_g        = 1'b0;
    accept         = 1'b0;

    // The held beat leaves whenever downstream takes it; an accept below overrides.
    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (found) begin
          gnt_next      = sel;
          credit_next   = (w_arr[sel] == '0) ? WWIDTH'(1) : w_arr[sel];
          boundary_next = 1'b1;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        // Single-entry register without skid: only accept when it is empty or draining.
        ready_g           = !out_valid_reg || out_ready;
        in_ready[gnt_reg] = ready_g;
        accept            = in_valid[gnt_reg] && ready_g;
        if (accept) begin
          out_valid_next = 1'b1;
          out_data_next  = d_arr[gnt_reg];
          out_last_next  = in_last[gnt_reg];
          out_src_next   = gnt_reg;
          if (in_last[gnt_reg]) begin
            credit_next   = credit_reg - 1'b1;
            boundary_next = 1'b1;
            if (credit_reg == WWIDTH'(1)) begin
              state_next = IDLE;
              ptr_next   = gnt_reg;
            end
          end else begin
            boundary_next = 1'b0;
          end
        end else if (boundary_reg && !in_valid[gnt_reg]) begin
          // Between packets with nothing pending: give the channel back.
          state_next = IDLE;
          ptr_next   = gnt_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= SWIDTH'(N_IN - 1);
      gnt_reg       <= '0;
      credit_reg    <= '0;
      boundary_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_src_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_reg       <= gnt_next;
      credit_reg    <= credit_next;
      boundary_reg  <= boundary_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      out_src_reg   <= out_src_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_src   = out_src_reg;

endmodule

// File: tb/tb_arbiter_wrr_pkt.sv
// tb_arbiter_wrr_pkt: directed scenarios plus randomized traffic for
// arbiter_wrr_pkt, compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_arbiter_wrr_pkt;

  localparam int DWIDTH = 20;
  localparam int N_IN   = 4;
  localparam int WWIDTH = 4;
  localparam int SWIDTH = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_IN-1:0]        in_valid;
  logic [N_IN*DWIDTH-1:0] in_data;
  logic [N_IN-1:0]        in_last;
  logic [N_IN-1:0]        in_ready;
  logic [N_IN*WWIDTH-1:0] weight;
  logic                   out_valid;
  logic [DWIDTH-1:0]      out_data;
  logic                   out_last;
  logic [SWIDTH-1:0]      out_src;
  logic                   out_ready;

  arbiter_wrr_pkt #(.DWIDTH(DWIDTH), .N_IN(N_IN), .WWIDTH(WWIDTH), .SWIDTH(SWIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .weight(weight),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic last; logic [DWIDTH-1:0] data; } beat_t;
  typedef struct packed { logic [SWIDTH-1:0] src; logic last; logic [DWIDTH-1:0] data; } obeat_t;

  beat_t           srcq [N_IN][$];   // per-requester pending beats (upstream sources)
  logic [N_IN-1:0] hold;             // force a requester's valid low
  int              wts [N_IN];
  logic [N_IN-1:0] acc_mask;         // beats taken at the coming edge

  obeat_t mq[$];                     // model: content of the output register
  int     owner, pkts_left, last_win;
  bit     between, armed;

  obeat_t log_q[$];
  int     log_cyc[$];
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    owner = -1; pkts_left = 0; between = 1'b1; last_win = N_IN - 1;
  endtask

  // Per-cycle compare against the model, then advance the model by one edge.
  task automatic model_cycle();
    logic [N_IN-1:0] exp_ready;
    obeat_t          nb;
    bit              acc;
    int              win, w, c;
    exp_ready = '0;
    if (owner >= 0 && (mq.size() == 0 || out_ready)) exp_ready[owner[SWIDTH-1:0]] = 1'b1;
    if (armed) begin
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("out_beat", 32'({out_src, out_last, out_data}), 32'(mq[0]));
    end
    acc_mask = rst ? '0 : (in_valid & in_ready);
    if (!rst && out_valid && out_ready) begin
      nb = {out_src, out_last, out_data};
      log_q.push_back(nb);
      log_cyc.push_back(cyc);
    end
    if (rst) begin
      model_reset();
    end else begin
      acc = (owner >= 0) && in_valid[owner] && exp_ready[owner];
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        nb.src  = owner[SWIDTH-1:0];
        nb.last = in_last[owner];
        nb.data = in_data[owner*DWIDTH +: DWIDTH];
        mq.push_back(nb);
      end
      if (owner < 0) begin
        win = -1;
        for (int k = N_IN; k >= 1; k--) begin
          c = (last_win + k) % N_IN;
          if (in_valid[c]) win = c;
        end
        if (win >= 0) begin
          owner = win;
          w = int'(weight[win*WWIDTH +: WWIDTH]);
          pkts_left = (w == 0) ? 1 : w;
          between = 1'b1;
        end
      end else if (acc) begin
        if (in_last[owner]) begin
          pkts_left--;
          between = 1'b1;
          if (pkts_left == 0) begin last_win = owner; owner = -1; end
        end else begin
          between = 1'b0;
        end
      end else if (between && !in_valid[owner]) begin
        last_win = owner; owner = -1;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_cycle();
  end

  task automatic apply_drive();
    for (int i = 0; i < N_IN; i++) begin
      in_valid[i] = (srcq[i].size() > 0) && !hold[i];
      if (srcq[i].size() > 0) begin
        in_data[i*DWIDTH +: DWIDTH] = srcq[i][0].data;
        in_last[i] = srcq[i][0].last;
      end else begin
        in_data[i*DWIDTH +: DWIDTH] = '0;
        in_last[i] = 1'b0;
      end
      weight[i*WWIDTH +: WWIDTH] = WWIDTH'(wts[i]);
    end
  endtask

  task automatic half_a();
    apply_drive();
    @(negedge clk);
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_IN; i++)
      if (acc_mask[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic push_pkt(input int i, input int base, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DWIDTH'(base + k);
      b.last = (k == len - 1);
      srcq[i].push_back(b);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N_IN; i++) begin srcq[i].delete(); wts[i] = 1; end
    hold = '0; out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    log_q.delete(); log_cyc.delete();
  endtask

  task automatic wait_beats(input int n, input int limit);
    int t;
    t = 0;
    while (log_q.size() < n && t < limit) begin tick(); t++; end
    check("beat_count", 32'(log_q.size()), 32'(n));
  endtask

  int t0, pend;
  int exp_src[8];

  initial begin
    in_valid = '0; in_data = '0; in_last = '0; weight = '0; out_ready = 1'b1; hold = '0;
    for (int i = 0; i < N_IN; i++) wts[i] = 1;
    model_reset();
    armed = 1'b0;
    rst = 1'b1;
    tick(); tick();
    armed = 1'b1;
    half_a();
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_out_beat", 32'({out_src, out_last, out_data}), 0);
    half_b();
    rst = 1'b0;

    // 1: single 3-beat packet on requester 2
    do_reset();
    push_pkt(2, 'h2A001, 3);
    t0 = cyc;
    wait_beats(3, 30);
    if (log_q.size() >= 3) begin
      check("t1_latency", 32'(log_cyc[0] - t0), 2);
      for (int k = 0; k < 3; k++) begin
        check("t1_src", 32'(log_q[k].src), 2);
        check("t1_last", 32'(log_q[k].last), (k == 2) ? 1 : 0);
        check("t1_data", 32'(log_q[k].data), 32'('h2A001 + k));
        if (k > 0) check("t1_gap", 32'(log_cyc[k] - log_cyc[k-1]), 1);
      end
    end
    half_a();
    check("t1_idle_valid", 32'(out_valid), 0);
    check("t1_idle_ready", 32'(in_ready), 0);
    half_b();

    // 2: all four requesters, 1-beat packets, weight 1
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N_IN; i++) push_pkt(i, i * 'h1000 + r, 1);
    exp_src = '{0, 1, 2, 3, 0, 1, 2, 3};
    wait_beats(8, 60);
    if (log_q.size() >= 8)
      for (int k = 0; k < 8; k++) begin
        check("t2_src", 32'(log_q[k].src), 32'(exp_src[k]));
        if (k > 0) check("t2_gap", 32'(log_cyc[k] - log_cyc[k-1]), 2);
      end

    // 3: weight 3 vs weight 1
    do_reset();
    wts[0] = 3;
    for (int r = 0; r < 6; r++) push_pkt(0, 'h30000 + r, 1);
    for (int r = 0; r < 2; r++) push_pkt(1, 'h31000 + r, 1);
    exp_src = '{0, 0, 0, 1, 0, 0, 0, 1};
    wait_beats(8, 60);
    if (log_q.size() >= 8)
      for (int k = 0; k < 8; k++) check("t3_src", 32'(log_q[k].src), 32'(exp_src[k]));

    // 4: downstream stall holds the output register
    do_reset();
    push_pkt(0, 'h40000, 4);
    tick(); tick();
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      half_a();
      check("t4_stall_valid", 32'(out_valid), 1);
      check("t4_stall_ready", 32'(in_ready), 0);
      check("t4_stall_data", 32'(out_data), 'h40000);
      check("t4_stall_last", 32'(out_last), 0);
      check("t4_stall_src", 32'(out_src), 0);
      half_b();
    end
    out_ready = 1'b1;
    wait_beats(4, 30);
    tick(); tick(); tick();
    check("t4_no_dup", 32'(log_q.size()), 4);
    if (log_q.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        check("t4_data", 32'(log_q[k].data), 32'('h40000 + k));
        check("t4_last", 32'(log_q[k].last), (k == 3) ? 1 : 0);
      end

    // 5: mid-packet gap on requester 0 while requester 1 waits
    do_reset();
    push_pkt(0, 'h50000, 4);
    push_pkt(1, 'h51000, 2);
    tick(); tick();
    hold[0] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      half_a();
      check("t5_hold_ready", 32'(in_ready), 'b0001);
      half_b();
    end
    hold[0] = 1'b0;
    wait_beats(6, 40);
    if (log_q.size() >= 6)
      for (int k = 0; k < 6; k++) begin
        check("t5_src", 32'(log_q[k].src), (k < 4) ? 0 : 1);
        check("t5_data", 32'(log_q[k].data), (k < 4) ? 32'('h50000 + k) : 32'('h51000 + k - 4));
      end

    // 6: reset mid-packet, pointer returns to its reset value
    do_reset();
    push_pkt(2, 'h62000, 1);
    wait_beats(1, 20);
    push_pkt(3, 'h63000, 4);
    wait_beats(2, 20);
    rst = 1'b1;
    half_a();
    check("t6_pre_valid", 32'(out_valid), 1);
    half_b();
    rst = 1'b0;
    for (int i = 0; i < N_IN; i++) srcq[i].delete();
    log_q.delete(); log_cyc.delete();
    push_pkt(0, 'h60000, 1);
    push_pkt(1, 'h61000, 1);
    push_pkt(3, 'h63100, 1);
    half_a();
    check("t6_post_valid", 32'(out_valid), 0);
    check("t6_post_ready", 32'(in_ready), 0);
    half_b();
    wait_beats(3, 30);
    if (log_q.size() >= 3) begin
      check("t6_first_src", 32'(log_q[0].src), 0);
      check("t6_second_src", 32'(log_q[1].src), 1);
      check("t6_third_src", 32'(log_q[2].src), 3);
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (srcq[i].size() < 3 && $urandom_range(0, 3) == 0)
          push_pkt(i, int'($urandom_range(0, 'hFFFFF)), int'($urandom_range(1, 4)));
        hold[i] = ($urandom_range(0, 9) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) wts[$urandom_range(0, N_IN - 1)] = int'($urandom_range(0, 15));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; hold = '0; out_ready = 1'b1;
    pend = 1;
    for (int n = 0; n < 400 && pend != 0; n++) begin
      tick();
      pend = out_valid ? 1 : 0;
      for (int i = 0; i < N_IN; i++) pend += srcq[i].size();
    end
    check("drain_pending", 32'(pend), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
